// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module      : clint
// Description : Core-local interrupt/exception sequencer. Detects ECALL,
//               EBREAK, MRET and the qualified timer interrupt in ID, stalls
//               the pipeline, writes MEPC/MCAUSE/MSTATUS through the csr_regs
//               clint port and issues a one-cycle redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module clint #(
    parameter logic [63:0] ECALL_CAUSE  = 64'd11,
    parameter logic [63:0] EBREAK_CAUSE = 64'd3,
    parameter logic [63:0] TIMER_CAUSE  = 64'h8000_0000_0000_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [63:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [63:0] jump_addr_i,
    input  logic        timer_irq_i,
    input  logic        global_int_en_i,
    input  logic [63:0] csr_mtvec_i,
    input  logic [63:0] csr_mepc_i,
    input  logic [63:0] csr_mstatus_i,
    output logic        we_o,
    output logic [63:0] waddr_o,
    output logic [63:0] data_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [63:0] int_addr_o
);

    localparam logic [31:0] c_inst_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_inst_ebreak = 32'h0010_0073;
    localparam logic [31:0] c_inst_mret   = 32'h3020_0073;

    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_w_mepc    = 3'd1;
    localparam logic [2:0] c_st_w_mcause  = 3'd2;
    localparam logic [2:0] c_st_w_mstatus = 3'd3;
    localparam logic [2:0] c_st_w_mret    = 3'd4;
    localparam logic [2:0] c_st_assert    = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [63:0] r_cause;
    logic [63:0] r_epc;
    logic [63:0] r_int_addr;

    logic w_idle;
    logic w_is_ecall;
    logic w_is_ebreak;
    logic w_is_sync;
    logic w_is_mret;
    logic w_timer;
    logic w_take_trap;
    logic w_take_mret;

    assign w_idle      = (r_state == c_st_idle);
    assign w_is_ecall  = (inst_i == c_inst_ecall);
    assign w_is_ebreak = (inst_i == c_inst_ebreak);
    assign w_is_sync   = w_is_ecall | w_is_ebreak;
    assign w_is_mret   = (inst_i == c_inst_mret);
    assign w_timer     = timer_irq_i & global_int_en_i;

    // Priority: synchronous exception > MRET > timer interrupt.
    assign w_take_trap = w_idle & (w_is_sync | (w_timer & ~w_is_mret));
    assign w_take_mret = w_idle & w_is_mret & ~w_is_sync;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_take_trap) begin
                    w_next_state = c_st_w_mepc;
                end else if (w_take_mret) begin
                    w_next_state = c_st_w_mret;
                end
            end
            c_st_w_mepc:    w_next_state = c_st_w_mcause;
            c_st_w_mcause:  w_next_state = c_st_w_mstatus;
            c_st_w_mstatus: w_next_state = c_st_assert;
            c_st_w_mret:    w_next_state = c_st_assert;
            c_st_assert:    w_next_state = c_st_idle;
            default:        w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cause    <= 64'd0;
            r_epc      <= 64'd0;
            r_int_addr <= 64'd0;
        end else begin
            r_state <= w_next_state;
            if (w_take_trap) begin
                if (w_is_ecall) begin
                    r_cause <= ECALL_CAUSE;
                    r_epc   <= inst_addr_i;
                end else if (w_is_ebreak) begin
                    r_cause <= EBREAK_CAUSE;
                    r_epc   <= inst_addr_i;
                end else begin
                    // An interrupt must resume at the EX redirect target if one is in flight.
                    r_cause <= TIMER_CAUSE;
                    r_epc   <= jump_flag_i ? jump_addr_i : inst_addr_i;
                end
            end
            if (r_state == c_st_w_mstatus) begin
                r_int_addr <= csr_mtvec_i;
            end else if (r_state == c_st_w_mret) begin
                r_int_addr <= csr_mepc_i;
            end
        end
    end

    always_comb begin
        we_o         = 1'b0;
        waddr_o      = 64'd0;
        data_o       = 64'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 64'd0;
        if (!rst) begin
            case (r_state)
                c_st_w_mepc: begin
                    we_o    = 1'b1;
                    waddr_o = {52'd0, c_csr_mepc};
                    data_o  = r_epc;
                end
                c_st_w_mcause: begin
                    we_o    = 1'b1;
                    waddr_o = {52'd0, c_csr_mcause};
                    data_o  = r_cause;
                end
                c_st_w_mstatus: begin
                    // MPIE <= MIE, MIE <= 0
                    we_o    = 1'b1;
                    waddr_o = {52'd0, c_csr_mstatus};
                    data_o  = {csr_mstatus_i[63:8], csr_mstatus_i[3],
                               csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
                end
                c_st_w_mret: begin
                    // MIE <= MPIE, MPIE <= 1
                    we_o    = 1'b1;
                    waddr_o = {52'd0, c_csr_mstatus};
                    data_o  = {csr_mstatus_i[63:8], 1'b1,
                               csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
                end
                c_st_assert: begin
                    int_assert_o = 1'b1;
                    int_addr_o   = r_int_addr;
                end
                default: begin
                end
            endcase
        end
    end

    assign hold_flag_o = ~rst & (~w_idle | w_take_trap | w_take_mret);

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint
// Description : Scoreboard bench for clint; a transaction-level reference model
//               schedules expected CSR writes and redirects, a monitor checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint;

    localparam logic [31:0] C_ECALL  = 32'h0000_0073;
    localparam logic [31:0] C_EBREAK = 32'h0010_0073;
    localparam logic [31:0] C_MRET   = 32'h3020_0073;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_i = C_NOP;
    logic [63:0] inst_addr_i = 64'd0;
    logic        jump_flag_i = 1'b0;
    logic [63:0] jump_addr_i = 64'd0;
    logic        timer_irq_i = 1'b0;
    logic        global_int_en_i = 1'b0;
    logic [63:0] csr_mtvec_i = 64'd0;
    logic [63:0] csr_mepc_i = 64'd0;
    logic [63:0] csr_mstatus_i = 64'd0;
    logic        we_o;
    logic [63:0] waddr_o;
    logic [63:0] data_o;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [63:0] int_addr_o;

    clint dut (
        .clk             (clk),
        .rst             (rst),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .timer_irq_i     (timer_irq_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .data_o          (data_o),
        .hold_flag_o     (hold_flag_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_int;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc        = -1;
    int   free_at    = 0;
    int   hold_until = -1;
    int   checks     = 0;
    int   passes     = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    endtask

    function automatic logic [63:0] trap_mstatus(input logic [63:0] m);
        logic [63:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] mret_mstatus(input logic [63:0] m);
        logic [63:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

    function automatic void push(input int c, input bit is_int, input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        e.cyc = c; e.is_int = is_int; e.addr = a; e.data = d;
        q.push_back(e);
    endfunction

    // Reference model: applied once per cycle after the inputs for that cycle are set.
    task automatic commit();
        bit          sync, mret, tmr;
        logic [63:0] cause, epc;
        if (rst) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].cyc >= cyc) q.delete(i);
            hold_until = cyc - 1;
            free_at    = cyc + 1;
            return;
        end
        if (cyc < free_at) return;
        sync = (inst_i == C_ECALL) || (inst_i == C_EBREAK);
        mret = (inst_i == C_MRET);
        tmr  = timer_irq_i && global_int_en_i;
        if (sync || (!mret && tmr)) begin
            if (inst_i == C_ECALL)       begin cause = 64'd11; epc = inst_addr_i; end
            else if (inst_i == C_EBREAK) begin cause = 64'd3;  epc = inst_addr_i; end
            else begin
                cause = 64'h8000_0000_0000_0007;
                epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
            end
            push(cyc + 1, 1'b0, 64'h341, epc);
            push(cyc + 2, 1'b0, 64'h342, cause);
            push(cyc + 3, 1'b0, 64'h300, trap_mstatus(csr_mstatus_i));
            push(cyc + 4, 1'b1, csr_mtvec_i, 64'd0);
            hold_until = cyc + 4;
            free_at    = cyc + 5;
        end else if (mret) begin
            push(cyc + 1, 1'b0, 64'h300, mret_mstatus(csr_mstatus_i));
            push(cyc + 2, 1'b1, csr_mepc_i, 64'd0);
            hold_until = cyc + 2;
            free_at    = cyc + 3;
        end
    endtask

    // CSR inputs only change while the model says the sequencer is idle.
    task automatic drive(input logic [31:0] inst, input logic [63:0] ia, input bit jf,
                         input logic [63:0] ja, input bit tirq, input bit gie, input bit r,
                         input logic [63:0] mst, input logic [63:0] mtvec, input logic [63:0] mepc);
        @(posedge clk);
        #1;
        cyc++;
        rst             = r;
        inst_i          = inst;
        inst_addr_i     = ia;
        jump_flag_i     = jf;
        jump_addr_i     = ja;
        timer_irq_i     = tirq;
        global_int_en_i = gie;
        if (cyc >= free_at) begin
            csr_mstatus_i = mst;
            csr_mtvec_i   = mtvec;
            csr_mepc_i    = mepc;
        end
        commit();
    endtask

    task automatic idle_n(input int n, input bit gie);
        for (int i = 0; i < n; i++)
            drive(C_NOP, 64'h8000_0100, 1'b0, 64'd0, 1'b0, gie, 1'b0,
                  csr_mstatus_i, csr_mtvec_i, csr_mepc_i);
    endtask

    // Monitor: compares DUT outputs with the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (cyc >= 0) begin
            chk("hold_flag", hold_flag_o == (cyc <= hold_until), {63'd0, hold_flag_o},
                {63'd0, cyc <= hold_until});
            if (we_o || int_assert_o) begin
                chk("output_expected", q.size() > 0 && q[0].cyc == cyc,
                    {62'd0, we_o, int_assert_o}, q.size() > 0 ? 64'(q[0].cyc) : 64'hffff_ffff);
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    if (q[0].is_int) begin
                        chk("int_assert", int_assert_o && !we_o && waddr_o == 64'd0,
                            {62'd0, we_o, int_assert_o}, 64'd1);
                        chk("int_addr", int_addr_o == q[0].addr, int_addr_o, q[0].addr);
                    end else begin
                        chk("csr_we", we_o && !int_assert_o && int_addr_o == 64'd0,
                            {62'd0, we_o, int_assert_o}, 64'd2);
                        chk("csr_waddr", waddr_o == q[0].addr, waddr_o, q[0].addr);
                        chk("csr_data", data_o == q[0].data, data_o, q[0].data);
                    end
                    void'(q.pop_front());
                end
            end else begin
                chk("no_missing_output", !(q.size() > 0 && q[0].cyc <= cyc), 64'd0,
                    q.size() > 0 ? q[0].addr : 64'd0);
                if (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
                chk("quiet_outputs", waddr_o == 64'd0 && data_o == 64'd0 && int_addr_o == 64'd0,
                    waddr_o | data_o | int_addr_o, 64'd0);
            end
        end
    end

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++)
            drive(C_NOP, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
        idle_n(2, 1'b0);

        // ECALL with MIE set.
        drive(C_ECALL, 64'h8000_0010, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0,
              64'h8, 64'h8000_1000, 64'd0);
        idle_n(6, 1'b0);

        // Timer while EX redirects.
        drive(C_NOP, 64'h8000_0050, 1'b1, 64'h8000_0200, 1'b1, 1'b1, 1'b0,
              64'h8, 64'h8000_1000, 64'd0);
        idle_n(6, 1'b0);

        // Timer masked by MIE=0.
        for (int i = 0; i < 3; i++)
            drive(C_NOP, 64'h8000_0060, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0,
                  64'h0, 64'h8000_1000, 64'd0);
        idle_n(2, 1'b0);

        // MRET.
        drive(C_MRET, 64'h8000_1040, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0,
              64'h80, 64'h8000_1000, 64'h8000_0014);
        idle_n(4, 1'b0);

        // ECALL and timer together, timer held; MIE dropped after the trap then restored.
        drive(C_ECALL, 64'h8000_0020, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0,
              64'h8, 64'h8000_1000, 64'd0);
        for (int i = 0; i < 4; i++)
            drive(C_NOP, 64'h8000_0024, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0,
                  64'h80, 64'h8000_1000, 64'd0);
        for (int i = 0; i < 3; i++)
            drive(C_NOP, 64'h8000_1000, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0,
                  64'h80, 64'h8000_1000, 64'd0);
        drive(C_NOP, 64'h8000_1004, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0,
              64'h88, 64'h8000_1000, 64'd0);
        idle_n(6, 1'b0);

        // EBREAK aborted by reset at T2.
        drive(C_EBREAK, 64'h8000_0030, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0,
              64'h8, 64'h8000_1000, 64'd0);
        drive(C_NOP, 64'h8000_0030, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0,
              64'h8, 64'h8000_1000, 64'd0);
        drive(C_NOP, 64'h8000_0030, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1,
              64'h8, 64'h8000_1000, 64'd0);
        idle_n(6, 1'b0);

        // EBREAK held in ID through ASSERT.
        for (int i = 0; i < 5; i++)
            drive(C_EBREAK, 64'h8000_0034, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0,
                  64'h8, 64'h8000_2000, 64'd0);
        idle_n(6, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] inst;
            case ($urandom_range(0, 7))
                0:       inst = C_ECALL;
                1:       inst = C_EBREAK;
                2:       inst = C_MRET;
                default: inst = $urandom;
            endcase
            drive(inst, {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0,
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end
        idle_n(8, 1'b0);

        @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size() == 0, 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
